// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
// The lookahead group width is fixed; the top rejects any other GROUP value.
package pipelined_cla_addsub_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Carry out of a lookahead group from its generate/propagate and carry-in.
    function automatic logic group_carry(input logic g, input logic p, input logic cin);
        return g | (p & cin);
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate.
// G and P depend only on the operands, so the inter-group carry chain never loops through here.
module cla_group4
    import pipelined_cla_addsub_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               g,
    output logic               p
);
    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] c;

    assign gb = a & b;
    assign pb = a ^ b;

    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign sum = pb ^ c;
    assign g   = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
               | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign p   = &pb;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one CW-bit chunk per stage, carry registered
// between stages, valid/ready flow control with per-stage valid bits and flags at the tail.
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int CW   = WIDTH / STAGES;
    localparam int NG   = CW / GROUP_W;
    localparam int LAST = STAGES - 1;

    if (GROUP != GROUP_W) begin : g_bad_group
        $error("pipelined_cla_addsub: GROUP must be 4");
    end
    if ((WIDTH % (GROUP_W * STAGES)) != 0) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a multiple of 4*STAGES");
    end

    op_e op;

    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] c_vec;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  mix_q [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];

    logic              acc;
    logic              last_v;
    logic              last_cout;
    logic              last_cmsb;
    logic [WIDTH-1:0]  last_mix;
    logic              ovf_q;
    logic              zero_q;

    assign op = op_e'(in_sub);

    // A stage loads when it or any stage downstream of it has room, or the consumer takes the output.
    always_comb begin
        acc = out_ready;
        ld  = '0;
        for (int k = LAST; k >= 0; k--) begin
            acc   = acc | ~v_vec[k];
            ld[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] s_mix;
        logic [WIDTH-1:0] s_b;
        logic             s_c;
        logic             s_v;
        logic [WIDTH-1:0] r_mix;
        logic [CW-1:0]    chunk_sum;
        logic [NG:0]      gc;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [WIDTH-1:0] mix_r;
        logic [WIDTH-1:0] b_r;
        logic             c_r;
        logic             v_r;

        // mix carries operand A above the current chunk and finished sum bits below it.
        if (k == 0) begin : g_src_in
            assign s_mix = in_a;
            assign s_b   = (op == OP_SUB) ? ~in_b : in_b;
            assign s_c   = (op == OP_SUB) ? 1'b1 : in_cin;
            assign s_v   = in_valid;
        end else begin : g_src_reg
            assign s_mix = mix_q[k-1];
            assign s_b   = b_q[k-1];
            assign s_c   = c_vec[k-1];
            assign s_v   = v_vec[k-1];
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group4 u_grp (
                .a   (s_mix[k*CW + g*GROUP_W +: GROUP_W]),
                .b   (s_b[k*CW + g*GROUP_W +: GROUP_W]),
                .cin (gc[g]),
                .sum (chunk_sum[g*GROUP_W +: GROUP_W]),
                .g   (gg[g]),
                .p   (gp[g])
            );
        end

        always_comb begin
            gc    = '0;
            gc[0] = s_c;
            for (int g = 0; g < NG; g++) begin
                gc[g+1] = group_carry(gg[g], gp[g], gc[g]);
            end
        end

        always_comb begin
            r_mix                = s_mix;
            r_mix[k*CW +: CW]    = chunk_sum;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                c_r   <= 1'b0;
                mix_r <= '0;
                b_r   <= '0;
            end else if (ld[k]) begin
                v_r <= s_v;
                if (s_v) begin
                    mix_r <= r_mix;
                    b_r   <= s_b;
                    c_r   <= gc[NG];
                end
            end
        end

        assign v_vec[k] = v_r;
        assign c_vec[k] = c_r;
        assign mix_q[k] = mix_r;
        assign b_q[k]   = b_r;

        if (k == LAST) begin : g_tail
            assign last_v    = s_v;
            assign last_cout = gc[NG];
            // Carry into the MSB recovered from the MSB sum and operand bits.
            assign last_cmsb = s_mix[WIDTH-1] ^ s_b[WIDTH-1] ^ chunk_sum[CW-1];
            assign last_mix  = r_mix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (ld[LAST] && last_v) begin
            ovf_q  <= last_cout ^ last_cmsb;
            zero_q <= (last_mix == '0);
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_vec[LAST];
    assign out_sum   = mix_q[LAST];
    assign out_cout  = c_vec[LAST];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: three configurations (32/2, 8/1, 64/4)
// checked against an arithmetic reference model with a per-instance in-order scoreboard.
module tb_pipelined_cla_addsub;

    localparam int WD  [3] = '{32, 8, 64};
    localparam int STG [3] = '{2, 1, 4};

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } dvec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] t_a [3];
    logic [63:0] t_b [3];
    logic        t_v [3];
    logic        t_sub [3];
    logic        t_cin [3];
    logic        t_ordy [3];

    logic [63:0] o_sum [3];
    logic        o_v [3];
    logic        o_irdy [3];
    logic        o_co [3];
    logic        o_of [3];
    logic        o_z [3];

    logic [31:0] sum_m;
    logic [7:0]  sum_s;
    logic [63:0] sum_w;
    logic irdy_m, ov_m, co_m, of_m, z_m;
    logic irdy_s, ov_s, co_s, of_s, z_s;
    logic irdy_w, ov_w, co_w, of_w, z_w;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_v[0]), .in_ready(irdy_m), .in_sub(t_sub[0]), .in_cin(t_cin[0]),
        .in_a(t_a[0][31:0]), .in_b(t_b[0][31:0]),
        .out_valid(ov_m), .out_ready(t_ordy[0]), .out_sum(sum_m),
        .out_cout(co_m), .out_ovf(of_m), .out_zero(z_m)
    );

    pipelined_cla_addsub #(.WIDTH(8), .GROUP(4), .STAGES(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_v[1]), .in_ready(irdy_s), .in_sub(t_sub[1]), .in_cin(t_cin[1]),
        .in_a(t_a[1][7:0]), .in_b(t_b[1][7:0]),
        .out_valid(ov_s), .out_ready(t_ordy[1]), .out_sum(sum_s),
        .out_cout(co_s), .out_ovf(of_s), .out_zero(z_s)
    );

    pipelined_cla_addsub #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_v[2]), .in_ready(irdy_w), .in_sub(t_sub[2]), .in_cin(t_cin[2]),
        .in_a(t_a[2]), .in_b(t_b[2]),
        .out_valid(ov_w), .out_ready(t_ordy[2]), .out_sum(sum_w),
        .out_cout(co_w), .out_ovf(of_w), .out_zero(z_w)
    );

    always_comb begin
        o_sum[0] = 64'(sum_m);  o_v[0] = ov_m; o_irdy[0] = irdy_m;
        o_co[0]  = co_m;        o_of[0] = of_m; o_z[0] = z_m;
        o_sum[1] = 64'(sum_s);  o_v[1] = ov_s; o_irdy[1] = irdy_s;
        o_co[1]  = co_s;        o_of[1] = of_s; o_z[1] = z_s;
        o_sum[2] = sum_w;       o_v[2] = ov_w; o_irdy[2] = irdy_w;
        o_co[2]  = co_w;        o_of[2] = of_w; o_z[2] = z_w;
    end

    // Reference: unsigned arithmetic for sum/carry, signed range check for overflow.
    function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin,
                                   output logic [63:0] sum, output logic cout,
                                   output logic ovf, output logic zero);
        logic [63:0]        mask;
        logic [64:0]        ua, ub, t;
        logic signed [66:0] sa, sb, rs, half, full2;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = {1'b0, a & mask};
        ub = {1'b0, b & mask};
        if (sub) begin
            t    = ua - ub;
            cout = (ua >= ub);
        end else begin
            t    = ua + ub + 65'(cin);
            cout = t[w];
        end
        sum   = t[63:0] & mask;
        zero  = (sum == 64'd0);
        full2 = 67'sd1 <<< w;
        half  = 67'sd1 <<< (w - 1);
        sa = $signed({3'b000, a & mask});
        sb = $signed({3'b000, b & mask});
        if (a[w-1]) sa = sa - full2;
        if (b[w-1]) sb = sb - full2;
        rs  = sub ? (sa - sb) : (sa + sb + $signed({66'd0, cin}));
        ovf = (rs >= half) || (rs < -half);
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] one;
        one = 64'd1;
        case ($urandom_range(7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return one << (w - 1);
            3:       return (one << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [63:0] bp_a(input int i);
        return {32'd0, 32'h0123_4567 * 32'(i + 1)};
    endfunction

    function automatic logic [63:0] bp_b(input int i);
        return {32'd0, 32'h89AB_CDEF ^ 32'(i)};
    endfunction

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            t_v[d] = 1'b0; t_sub[d] = 1'b0; t_cin[d] = 1'b0;
            t_a[d] = 64'd0; t_b[d] = 64'd0; t_ordy[d] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({o_v[d], o_sum[d], o_co[d], o_of[d], o_z[d]} !== 68'd0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got v=%b sum=%h c=%b o=%b z=%b required all 0",
                         d, o_v[d], o_sum[d], o_co[d], o_of[d], o_z[d]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (o_irdy[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_in_ready[%0d]: got %b required 1", d, o_irdy[d]);
            end
        end
    endtask

    task automatic test_directed();
        dvec_t dv [7];
        logic [34:0] got, exp;
        dv[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        dv[1] = '{32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        dv[2] = '{32'h8000_0000, 32'd1,         1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        dv[3] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        dv[4] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        dv[5] = '{32'd1,         32'd2,         1'b0, 1'b1, 32'd4,         1'b0, 1'b0, 1'b0};
        dv[6] = '{32'd3,         32'd3,         1'b1, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            t_v[0] = 1'b1; t_a[0] = {32'd0, dv[i].a}; t_b[0] = {32'd0, dv[i].b};
            t_sub[0] = dv[i].sub; t_cin[0] = dv[i].cin; t_ordy[0] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (o_irdy[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_in_ready[%0d]: got %b required 1", i, o_irdy[0]);
            end
            @(posedge clk); #1;
            t_v[0] = 1'b0;
            n_cmp++;
            if (o_v[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL directed_early_valid[%0d]: got %b required 0", i, o_v[0]);
            end
            @(posedge clk); #1;
            got = {o_v[0], o_sum[0][31:0], o_co[0], o_of[0], o_z[0]};
            exp = {1'b1, dv[i].sum, dv[i].cout, dv[i].ovf, dv[i].zero};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL directed_result[%0d]: got {v,sum,c,o,z}=%h required %h", i, got, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [63:0] a_l [3];
        logic [63:0] b_l [3];
        res_t        r;
        a_l[1] = 64'h0000_0000_0000_00FF; b_l[1] = 64'd1;
        a_l[2] = 64'h7FFF_FFFF_FFFF_FFFF; b_l[2] = 64'd1;
        for (int d = 1; d < 3; d++) begin
            ref_op(WD[d], a_l[d], b_l[d], 1'b0, 1'b0, r.sum, r.cout, r.ovf, r.zero);
            @(posedge clk); #1;
            t_v[d] = 1'b1; t_a[d] = a_l[d]; t_b[d] = b_l[d];
            t_sub[d] = 1'b0; t_cin[d] = 1'b0; t_ordy[d] = 1'b1;
            @(posedge clk); #1;
            t_v[d] = 1'b0;
            for (int e = 1; e < STG[d]; e++) begin
                n_cmp++;
                if (o_v[d] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_early[%0d] edge %0d: got %b required 0", d, e, o_v[d]);
                end
                @(posedge clk); #1;
            end
            n_cmp++;
            if ({o_v[d], o_sum[d], o_co[d], o_of[d], o_z[d]} !== {1'b1, r.sum, r.cout, r.ovf, r.zero}) begin
                n_bad++;
                $display("FAIL latency_result[%0d]: got v=%b sum=%h c=%b o=%b z=%b required 1 %h %b %b %b",
                         d, o_v[d], o_sum[d], o_co[d], o_of[d], o_z[d], r.sum, r.cout, r.ovf, r.zero);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int          sent;
        int          got_n;
        logic        stall_seen;
        logic        held;
        logic [66:0] prev, cur, exp;
        res_t        r;
        sent = 0; got_n = 0; stall_seen = 1'b0; held = 1'b0; prev = '0;
        t_cin[0] = 1'b0;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            @(posedge clk); #1;
            t_v[0]    = (sent < 8);
            t_a[0]    = bp_a(sent);
            t_b[0]    = bp_b(sent);
            t_sub[0]  = sent[0];
            t_ordy[0] = !(c >= 3 && c < 6);
            @(negedge clk);
            cur = {o_sum[0], o_co[0], o_of[0], o_z[0]};
            n_cmp++;
            if (o_irdy[0] !== (((sent - got_n) < 2) || t_ordy[0])) begin
                n_bad++;
                $display("FAIL bp_in_ready cycle %0d: got %b required %b", c, o_irdy[0],
                         (((sent - got_n) < 2) || t_ordy[0]));
            end
            if (!o_irdy[0]) stall_seen = 1'b1;
            if (held) begin
                n_cmp++;
                if (o_v[0] !== 1'b1 || cur !== prev) begin
                    n_bad++;
                    $display("FAIL bp_hold cycle %0d: got v=%b %h required 1 %h", c, o_v[0], cur, prev);
                end
            end
            if (o_v[0] && t_ordy[0]) begin
                ref_op(32, bp_a(got_n), bp_b(got_n), got_n[0], 1'b0, r.sum, r.cout, r.ovf, r.zero);
                exp = {r.sum, r.cout, r.ovf, r.zero};
                n_cmp++;
                if (cur !== exp) begin
                    n_bad++;
                    $display("FAIL bp_beat[%0d]: got %h required %h", got_n, cur, exp);
                end
                got_n++;
            end
            if (t_v[0] && o_irdy[0]) sent++;
            held = o_v[0] && !t_ordy[0];
            prev = cur;
        end
        n_cmp++;
        if (got_n != 8) begin
            n_bad++;
            $display("FAIL bp_count: got %0d beats required 8", got_n);
        end
        n_cmp++;
        if (stall_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall: in_ready never low, required low while full and held");
        end
        @(posedge clk); #1;
        t_v[0] = 1'b0; t_ordy[0] = 1'b1;
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        t_v[0] = 1'b1; t_a[0] = 64'd1; t_b[0] = 64'd2; t_sub[0] = 1'b0; t_cin[0] = 1'b0;
        t_ordy[0] = 1'b0;
        @(posedge clk); #1;
        t_a[0] = 64'd3; t_b[0] = 64'd4;
        @(posedge clk); #1;
        t_v[0] = 1'b0;
        n_cmp++;
        if (o_v[0] !== 1'b1 || o_irdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_full: got v=%b rdy=%b required v=1 rdy=0", o_v[0], o_irdy[0]);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if (o_v[0] !== 1'b0 || o_sum[0] !== 64'd0) begin
            n_bad++;
            $display("FAIL midflight_reset: got v=%b sum=%h required 0 0", o_v[0], o_sum[0]);
        end
        t_ordy[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (o_v[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL midflight_emit cycle %0d: got out_valid %b required 0", c, o_v[0]);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        res_t        ring [3][16];
        int          head [3];
        int          cnt [3];
        logic        held [3];
        logic [66:0] prev [3];
        logic [66:0] got, exp;
        res_t        r;
        for (int d = 0; d < 3; d++) begin
            head[d] = 0; cnt[d] = 0; held[d] = 1'b0; prev[d] = '0;
        end
        for (int c = 0; c < cycles + 20; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (c < cycles) begin
                    t_v[d]    = ($urandom_range(3) != 0);
                    t_a[d]    = rnd_op(WD[d]);
                    t_b[d]    = rnd_op(WD[d]);
                    t_sub[d]  = $urandom_range(1) == 1;
                    t_cin[d]  = $urandom_range(1) == 1;
                    t_ordy[d] = ($urandom_range(2) != 0);
                end else begin
                    t_v[d]    = 1'b0;
                    t_ordy[d] = 1'b1;
                end
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                got = {o_sum[d], o_co[d], o_of[d], o_z[d]};
                n_cmp++;
                if (o_irdy[d] !== ((cnt[d] < STG[d]) || t_ordy[d])) begin
                    n_bad++;
                    $display("FAIL rnd_in_ready[%0d] cycle %0d: got %b required %b", d, c, o_irdy[d],
                             ((cnt[d] < STG[d]) || t_ordy[d]));
                end
                if (held[d]) begin
                    n_cmp++;
                    if (o_v[d] !== 1'b1 || got !== prev[d]) begin
                        n_bad++;
                        $display("FAIL rnd_hold[%0d] cycle %0d: got v=%b %h required 1 %h",
                                 d, c, o_v[d], got, prev[d]);
                    end
                end
                if (o_v[d] && t_ordy[d]) begin
                    n_cmp++;
                    if (cnt[d] == 0) begin
                        n_bad++;
                        $display("FAIL rnd_extra[%0d] cycle %0d: got beat %h required none", d, c, got);
                    end else begin
                        r   = ring[d][head[d]];
                        exp = {r.sum, r.cout, r.ovf, r.zero};
                        if (got !== exp) begin
                            n_bad++;
                            $display("FAIL rnd_beat[%0d] cycle %0d: got %h required %h", d, c, got, exp);
                        end
                        head[d] = (head[d] + 1) % 16;
                        cnt[d]--;
                    end
                end
                if (t_v[d] && o_irdy[d]) begin
                    ref_op(WD[d], t_a[d], t_b[d], t_sub[d], t_cin[d], r.sum, r.cout, r.ovf, r.zero);
                    ring[d][(head[d] + cnt[d]) % 16] = r;
                    cnt[d]++;
                end
                held[d] = o_v[d] && !t_ordy[d];
                prev[d] = got;
            end
        end
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (cnt[d] != 0) begin
                n_bad++;
                $display("FAIL rnd_drain[%0d]: got %0d beats outstanding required 0", d, cnt[d]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_backpressure();
        test_reset_midflight();
        test_random(6000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
